// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC: datapath widths, FSM
// state encoding and the arithmetic helpers used by the pipeline.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 21;
    localparam int TAPS   = 9;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);

    typedef enum logic [2:0] {
        sIDLE  = 3'b001,
        sRUN   = 3'b010,
        sDRAIN = 3'b100
    } state_t;

    // Unsigned pixel times signed coefficient; the 17-bit result cannot overflow.
    function automatic logic signed [PROD_W-1:0] pix_mul(
        input logic        [PIX_W-1:0]  pix,
        input logic signed [COEF_W-1:0] coef
    );
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-PIX_W){1'b0}}, pix};
        b = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
        return a * b;
    endfunction

    // Clamp a signed sum into the 0..255 pixel range.
    function automatic logic signed [ACC_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])
            return '0;
        else if (v > SAT_MAX)
            return SAT_MAX;
        else
            return v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Pixel shift store of 2N+3 taps with the 3x3 window picked out of it.
// Window byte 8 (bits [71:64]) is the oldest tap (top-left), byte 0 the newest.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    shift,
    input  logic [PIX_W-1:0]        data_in,
    output logic [TAPS*PIX_W-1:0]   window
);

    localparam int DEPTH = 2*N + 3;

    logic [PIX_W-1:0] taps_reg [DEPTH];

    // Shift a new pixel into tap 0; clearing wins over shifting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++)
                taps_reg[i] <= '0;
        end else if (shift) begin
            taps_reg[0] <= data_in;
            for (int i = 1; i < DEPTH; i++)
                taps_reg[i] <= taps_reg[i-1];
        end
    end

    // Row gi / column gj of the window sits N taps per row and 1 tap per column back.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            for (genvar gj = 0; gj < 3; gj++) begin : g_col
                assign window[(TAPS-1-(gi*3+gj))*PIX_W +: PIX_W] = taps_reg[(2-gi)*N + (2-gj)];
            end
        end
    endgenerate

endmodule

// File: rtl/conv_window_mac.sv
// 3x3 convolution MAC: two-stage pipeline (products, then sum), frame FSM
// and issue counter. Define CONV_SATURATE_EN to clamp results to 0..255;
// by default the raw signed 21-bit sum is presented.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIX_W-1:0]            data_in,
    input  logic                        data_write,
    input  logic                        enable,
    input  logic [TAPS*COEF_W-1:0]      filter,
    output logic signed [ACC_W-1:0]     pixel_out,
    output logic                        out_valid,
    output logic                        frame_done
);

    localparam int TOTAL = (N-2)*(N-2);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    state_t state_reg, state_next;
    logic [CNT_W-1:0] issue_cnt_reg;
    logic issue, last_issue, store_clear, store_shift;

    logic [TAPS*PIX_W-1:0] window;
    logic signed [PROD_W-1:0] prod_next [TAPS];
    logic signed [PROD_W-1:0] prod_reg  [TAPS];
    logic valid1_reg, last1_reg, valid2_reg, last2_reg;
    logic signed [ACC_W-1:0] sum_next, result_next, acc_reg;

    conv_line_buffer #(.N(N)) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (store_clear),
        .shift   (store_shift),
        .data_in (data_in),
        .window  (window)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= sIDLE;
        else
            state_reg <= state_next;
    end

    // Next state plus shift/issue/clear strobes; enable only counts in sRUN.
    always_comb begin
        state_next  = state_reg;
        issue       = 1'b0;
        last_issue  = 1'b0;
        store_clear = 1'b0;
        store_shift = 1'b0;
        case (state_reg)
            sIDLE: begin
                store_shift = data_write;
                if (data_write)
                    state_next = sRUN;
            end
            sRUN: begin
                store_shift = data_write;
                issue       = enable;
                if (enable && (issue_cnt_reg == LAST_CNT)) begin
                    last_issue = 1'b1;
                    state_next = sDRAIN;
                end
            end
            sDRAIN: begin
                if (!valid1_reg && !valid2_reg) begin
                    store_clear = 1'b1;
                    state_next  = sIDLE;
                end
            end
            default: begin
                store_clear = 1'b1;
                state_next  = sIDLE;
            end
        endcase
    end

    // Issued-window counter, cleared when the frame returns to idle.
    always_ff @(posedge clk) begin
        if (rst || store_clear)
            issue_cnt_reg <= '0;
        else if (issue)
            issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
    end

    // One multiplier per window position, coefficient c0 in the top byte.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_mul
            assign prod_next[gi] = pix_mul(window[(TAPS-1-gi)*PIX_W +: PIX_W],
                                           filter[(TAPS-1-gi)*COEF_W +: COEF_W]);
        end
    endgenerate

    // Stage 1: capture the nine products of the pre-shift window.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_reg <= 1'b0;
            last1_reg  <= 1'b0;
            for (int i = 0; i < TAPS; i++)
                prod_reg[i] <= '0;
        end else begin
            valid1_reg <= issue;
            last1_reg  <= last_issue;
            if (issue) begin
                for (int i = 0; i < TAPS; i++)
                    prod_reg[i] <= prod_next[i];
            end
        end
    end

    // Adder tree over the registered products, optionally clamped.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < TAPS; i++)
            sum_next = sum_next + ACC_W'(prod_reg[i]);
`ifdef CONV_SATURATE_EN
        result_next = clamp_u8(sum_next);
`else
        result_next = sum_next;
`endif
    end

    // Stage 2: register the result; it holds while no new result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid2_reg <= 1'b0;
            last2_reg  <= 1'b0;
            acc_reg    <= '0;
        end else begin
            valid2_reg <= valid1_reg;
            last2_reg  <= last1_reg;
            if (valid1_reg)
                acc_reg <= result_next;
        end
    end

    // Outputs read as zero for the whole reset cycle, not just after the edge.
    assign pixel_out  = rst ? '0 : acc_reg;
    assign out_valid  = valid2_reg & ~rst;
    assign frame_done = last2_reg & ~rst;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac (N=4): directed frames with known
// answers, a mid-frame reset, then randomized frames against an image-level
// reference model. Works with or without CONV_SATURATE_EN.
`timescale 1ns/1ps
module tb_conv_window_mac;
    import conv_pkg::*;

    localparam int N     = 4;
    localparam int TOTAL = (N-2)*(N-2);
    localparam logic [71:0] F_ID   = 72'h00000000_01_00000000;
    localparam logic [71:0] F_ONES = 72'h01_01_01_01_01_01_01_01_01;
    localparam logic [71:0] F_7F   = 72'h7F_7F_7F_7F_7F_7F_7F_7F_7F;
    localparam logic [71:0] F_FF   = 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data_in = '0;
    logic data_write = 1'b0;
    logic enable = 1'b0;
    logic [71:0] filter = '0;
    logic signed [20:0] pixel_out;
    logic out_valid;
    logic frame_done;

    conv_window_mac #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_write (data_write),
        .enable     (enable),
        .filter     (filter),
        .pixel_out  (pixel_out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [20:0] val;
        logic               last;
        int                 due;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    logic signed [20:0] last_exp = '0;
    bit rst_prev = 1'b1;
    bit end_req = 1'b0;
    bit end_done = 1'b0;
    exp_t mon_e;

    // Reference model state: pixels written in this frame, in write order.
    logic [7:0] pix_list[$];
    bit frame_open = 1'b0;
    int issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Convolution of the 3x3 image neighbourhood around the pixel written N+1 writes ago.
    function automatic logic signed [20:0] ref_conv(input logic [71:0] f);
        int w;
        int center;
        int idx;
        int p;
        int acc;
        logic signed [7:0] cf;
        w = pix_list.size();
        center = w - 1 - (N + 1);
        acc = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                idx = center + dr*N + dc;
                p = (idx >= 0 && idx < w) ? int'(pix_list[idx]) : 0;
                cf = f[8*(8 - ((dr+1)*3 + (dc+1))) +: 8];
                acc += p * cf;
            end
        end
`ifdef CONV_SATURATE_EN
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
`endif
        return 21'(acc);
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    // Drive one cycle; the model sees the enable before the write (pre-shift window).
    task automatic tick(input bit w, input logic [7:0] d, input bit e,
                        input logic [71:0] f, input bit use_c, input int c_val);
        exp_t x;
        bit draining;
        data_write = w;
        data_in    = d;
        enable     = e;
        filter     = f;
        draining   = (issued == TOTAL);
        if (e && frame_open && !draining) begin
            issued++;
            x.val  = use_c ? 21'(c_val) : ref_conv(f);
            x.last = (issued == TOTAL);
            x.due  = cyc + 2;
            sb.push_back(x);
        end
        if (w && !draining) begin
            pix_list.push_back(d);
            frame_open = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // After the last enable: a few ignored writes/enables in drain, then quiet until idle.
    task automatic finish_frame();
        for (int i = 0; i < 3; i++)
            tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), rand72(), 0, 0);
        for (int i = 0; i < 4; i++)
            tick(0, 8'h00, 0, filter, 0, 0);
        pix_list.delete();
        frame_open = 1'b0;
        issued = 0;
    endtask

    // Pixels 1..16 (or a constant); windows centred at 6, 7, 10, 11.
    task automatic directed_frame(input logic [71:0] f, input bit together,
                                  input bit const_pix, input logic [7:0] cpix,
                                  input int e0, input int e1, input int e2, input int e3);
        int ev[4];
        int k;
        logic [7:0] px;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        k = 0;
        for (int i = 1; i <= 16; i++) begin
            px = const_pix ? cpix : 8'(i);
            if (together && (i == 12 || i == 13 || i == 16)) begin
                tick(1, px, 1, f, 1, ev[k]);
                k++;
            end else begin
                tick(1, px, 0, f, 0, 0);
            end
            if (!together && (i == 11 || i == 12 || i == 15 || i == 16)) begin
                tick(0, 8'h00, 1, f, 1, ev[k]);
                k++;
            end
        end
        if (together)
            tick(0, 8'h00, 1, f, 1, ev[k]);
        finish_frame();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        data_write = 1'b0;
        enable = 1'b0;
        sb.delete();
        pix_list.delete();
        frame_open = 1'b0;
        issued = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic random_frame();
        int guard;
        bit w;
        bit e;
        tick(0, 8'h00, 1, rand72(), 0, 0);      // enable while idle: ignored
        guard = 0;
        while (issued < TOTAL) begin
            guard++;
            w = ($urandom_range(0, 3) != 0) || (pix_list.size() == 0);
            e = (pix_list.size() >= 6) && (($urandom_range(0, 2) == 0) || guard > 60);
            tick(w, 8'($urandom), e, rand72(), 0, 0);
        end
        finish_frame();
    endtask

    // Monitor: pops the scoreboard on each output, checks hold/zero values otherwise.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if (out_valid !== 1'b0 || pixel_out !== 21'sd0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got valid=%b out=%0d done=%b, need 0/0/0",
                         out_valid, pixel_out, frame_done);
            end
            last_exp = '0;
        end else begin
            if (rst_prev) begin
                n_vec++;
                if (dut.state_reg !== sIDLE) begin
                    n_err++;
                    $display("FAIL state_after_reset: got %b, need %b", dut.state_reg, sIDLE);
                end
            end
            if (out_valid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %0d at cycle %0d, need no output",
                             pixel_out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (pixel_out !== mon_e.val || frame_done !== mon_e.last || cyc != mon_e.due) begin
                        n_err++;
                        $display("FAIL output: got %0d done=%b cycle %0d, need %0d done=%b cycle %0d",
                                 pixel_out, frame_done, cyc, mon_e.val, mon_e.last, mon_e.due);
                    end
                    last_exp = mon_e.val;
                end
            end else begin
                n_vec++;
                if (out_valid !== 1'b0 || pixel_out !== last_exp || frame_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_hold: got valid=%b out=%0d done=%b, need 0/%0d/0",
                             out_valid, pixel_out, frame_done, last_exp);
                end
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    n_vec++;
                    n_err++;
                    mon_e = sb.pop_front();
                    $display("FAIL missing_output: none by cycle %0d, need %0d due cycle %0d",
                             cyc, mon_e.val, mon_e.due);
                end
            end
            if (end_req && !end_done) begin
                n_vec++;
                if (sb.size() != 0) begin
                    n_err++;
                    $display("FAIL drain_empty: got %0d pending, need 0", sb.size());
                end
                end_done = 1'b1;
            end
        end
        rst_prev = rst;
    end

    initial begin
        do_reset(3);
        repeat (2) tick(0, 8'h00, 0, '0, 0, 0);

        directed_frame(F_ID,   0, 0, 8'h00, 6, 7, 10, 11);
        directed_frame(F_ONES, 0, 0, 8'h00, 54, 63, 90, 99);
`ifdef CONV_SATURATE_EN
        directed_frame(F_7F, 0, 1, 8'hFF, 255, 255, 255, 255);
        directed_frame(F_FF, 0, 1, 8'd10, 0, 0, 0, 0);
`else
        directed_frame(F_7F, 0, 1, 8'hFF, 291465, 291465, 291465, 291465);
        directed_frame(F_FF, 0, 1, 8'd10, -90, -90, -90, -90);
`endif
        directed_frame(F_ID, 1, 0, 8'h00, 6, 7, 10, 11);

        // Reset one cycle after the 2nd enable: only the first result survives.
        for (int i = 1; i <= 11; i++)
            tick(1, 8'(i), 0, F_ID, 0, 0);
        tick(0, 8'h00, 1, F_ID, 1, 6);
        tick(1, 8'd12, 0, F_ID, 0, 0);
        tick(0, 8'h00, 1, F_ID, 1, 7);
        do_reset(1);
        repeat (4) tick(0, 8'h00, 0, F_ID, 0, 0);
        directed_frame(F_ID, 0, 0, 8'h00, 6, 7, 10, 11);

        for (int fr = 0; fr < 30; fr++)
            random_frame();

        repeat (4) tick(0, 8'h00, 0, '0, 0, 0);
        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
